// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM demultiplexer: FSM state type, default slot count,
// and a helper for sizing slot indices.
package tdm_pkg;

  localparam int unsigned TDM_SLOTS_DEFAULT = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } tdm_state_e;

  // Slot index width, never narrower than one bit.
  function automatic int unsigned slotWidth(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Slot counter for the TDM demultiplexer: counts captured slots, wraps after N-1,
// supports synchronous clear to 0 or load to 1 on a frame sync.
module tdm_slot_cnt
  import tdm_pkg::*;
#(
  parameter int unsigned N  = TDM_SLOTS_DEFAULT,
  parameter int unsigned SW = slotWidth(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          load1_i,
  input  logic          clr_i,
  output logic [SW-1:0] slot_o,
  output logic          tc_o
);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  assign tc_o   = (slot_q == SW'(N - 1));
  assign slot_o = slot_q;

  // A frame sync outranks advancing; clear outranks both.
  always_comb begin
    slot_d = slot_q;
    if (clr_i) begin
      slot_d = '0;
    end else if (load1_i) begin
      slot_d = SW'(1);
    end else if (en_i) begin
      slot_d = tc_o ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/tdm_demux_8.sv
// Serial-to-parallel TDM demultiplexer: gathers N qualified serial bits into a frame
// and hands completed frames to a valid/ready consumer, flagging drops and resyncs.
module tdm_demux_8
  import tdm_pkg::*;
#(
  parameter int unsigned N  = TDM_SLOTS_DEFAULT,
  parameter int unsigned SW = slotWidth(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_valid,
  input  logic          start,
  output logic [SW-1:0] slot,
  output logic [N-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          overrun,
  output logic          sync_err
);

  tdm_state_e   state_q;
  logic [N-1:0] buf_q;
  logic [N-1:0] buf_d;
  logic [N-1:0] dout_q;
  logic         dout_valid_q;
  logic         overrun_q;
  logic         sync_err_q;

  logic [SW-1:0] slot_w;
  logic          tc_w;
  logic          syncCap;
  logic          advance;
  logic          complete;
  logic          loadOut;

  assign syncCap  = din_valid && start;
  assign advance  = din_valid && !start && (state_q == COLLECT);
  assign complete = advance && tc_w;
  assign loadOut  = complete && (!dout_valid_q || dout_ready);

  tdm_slot_cnt #(
    .N  (N),
    .SW (SW)
  ) u_slot_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (advance),
    .load1_i (syncCap),
    .clr_i   (1'b0),
    .slot_o  (slot_w),
    .tc_o    (tc_w)
  );

  // A sync restarts the buffer from scratch so stale bits of a broken frame never leak.
  always_comb begin
    buf_d = buf_q;
    if (syncCap) begin
      buf_d    = '0;
      buf_d[0] = din;
    end else if (advance) begin
      buf_d[slot_w] = din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      overrun_q  <= 1'b0;
      sync_err_q <= 1'b0;
      buf_q      <= buf_d;

      if (syncCap) begin
        state_q    <= COLLECT;
        sync_err_q <= (state_q == COLLECT);
      end else if (complete) begin
        state_q <= IDLE;
      end

      // A fresh frame may replace the one being handed off in the same cycle.
      if (loadOut) begin
        dout_q       <= buf_d;
        dout_valid_q <= 1'b1;
      end else begin
        if (complete) begin
          overrun_q <= 1'b1;
        end
        if (dout_valid_q && dout_ready) begin
          dout_valid_q <= 1'b0;
        end
      end
    end
  end

  assign slot       = slot_w;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign overrun    = overrun_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Self-checking bench for tdm_demux_8: directed scenarios plus random traffic,
// compared every cycle against a frame-level reference model.
module tb_tdm_demux_8;

  localparam int N  = 8;
  localparam int SW = 3;

  logic          clk;
  logic          rst_n;
  logic          din;
  logic          din_valid;
  logic          start;
  logic [SW-1:0] slot;
  logic [N-1:0]  dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          overrun;
  logic          sync_err;

  int checkCount;
  int passCount;

  // Reference model: frame progress as a bit count plus collected bits.
  bit           mInFrame;
  int           mCnt;
  logic [N-1:0] mBits;
  logic [N-1:0] mDout;
  logic         mValid;
  logic         mOverrun;
  logic         mSyncErr;

  int tickNo;

  tdm_demux_8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .start      (start),
    .slot       (slot),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .overrun    (overrun),
    .sync_err   (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h (tick %0d)", tag, observed, expected, tickNo);
  endtask

  task automatic modelReset();
    mInFrame = 1'b0;
    mCnt     = 0;
    mBits    = '0;
    mDout    = '0;
    mValid   = 1'b0;
    mOverrun = 1'b0;
    mSyncErr = 1'b0;
  endtask

  task automatic modelStep();
    bit complete;
    complete = 1'b0;
    mOverrun = 1'b0;
    mSyncErr = 1'b0;
    if (!rst_n) begin
      modelReset();
      return;
    end
    if (din_valid) begin
      if (start) begin
        mSyncErr = mInFrame;
        mInFrame = 1'b1;
        mBits    = '0;
        mBits[0] = din;
        mCnt     = 1;
      end else if (mInFrame) begin
        mBits[mCnt] = din;
        mCnt++;
        if (mCnt == N) begin
          complete = 1'b1;
          mInFrame = 1'b0;
          mCnt     = 0;
        end
      end
    end
    if (complete && (!mValid || dout_ready)) begin
      mDout  = mBits;
      mValid = 1'b1;
    end else if (complete) begin
      mOverrun = 1'b1;
    end else if (mValid && dout_ready) begin
      mValid = 1'b0;
    end
  endtask

  task automatic compareAll();
    checkOutput("slot", 32'(slot), 32'(mCnt));
    checkOutput("dout", 32'(dout), 32'(mDout));
    checkOutput("dout_valid", 32'(dout_valid), 32'(mValid));
    checkOutput("overrun", 32'(overrun), 32'(mOverrun));
    checkOutput("sync_err", 32'(sync_err), 32'(mSyncErr));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare 1ns later.
  task automatic applyStimulus(input logic d, input logic dv, input logic st, input logic rdy);
    din        = d;
    din_valid  = dv;
    start      = st;
    dout_ready = rdy;
    @(posedge clk);
    modelStep();
    tickNo++;
    #1;
    compareAll();
  endtask

  task automatic sendBits(input logic [N-1:0] value, input int first, input int last,
                          input bit withStart, input logic rdy);
    for (int k = first; k <= last; k++) begin
      applyStimulus(value[k], 1'b1, withStart && (k == first), rdy);
    end
  endtask

  initial begin
    int validTicks[$];
    int t0;
    bit sawOverrun;

    checkCount = 0;
    passCount  = 0;
    tickNo     = 0;
    modelReset();
    din        = 1'b0;
    din_valid  = 1'b0;
    start      = 1'b0;
    dout_ready = 1'b0;
    rst_n      = 1'b0;

    #2;
    checkOutput("reset_slot", 32'(slot), 32'd0);
    checkOutput("reset_dout_valid", 32'(dout_valid), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    #3 rst_n = 1'b1;

    // Frame 0xA7 with consumer ready.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    sendBits(8'hA7, 0, 7, 1'b1, 1'b1);
    checkOutput("a7_dout", 32'(dout), 32'hA7);
    checkOutput("a7_valid", 32'(dout_valid), 32'd1);
    checkOutput("a7_slot", 32'(slot), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("a7_consumed", 32'(dout_valid), 32'd0);

    // Same frame with a 3-cycle gap after slot 3.
    t0 = tickNo;
    sendBits(8'hA7, 0, 3, 1'b1, 1'b1);
    for (int g = 0; g < 3; g++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("gap_slot_hold", 32'(slot), 32'd4);
    end
    sendBits(8'hA7, 4, 7, 1'b0, 1'b1);
    checkOutput("gap_latency", 32'(tickNo - t0), 32'd11);
    checkOutput("gap_dout", 32'(dout), 32'hA7);
    checkOutput("gap_valid", 32'(dout_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: 0xA7 held, 0x3C dropped.
    sendBits(8'hA7, 0, 7, 1'b1, 1'b0);
    sendBits(8'h3C, 0, 7, 1'b1, 1'b0);
    checkOutput("bp_overrun", 32'(overrun), 32'd1);
    checkOutput("bp_dout_kept", 32'(dout), 32'hA7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_overrun_pulse", 32'(overrun), 32'd0);
    checkOutput("bp_still_valid", 32'(dout_valid), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_drain", 32'(dout_valid), 32'd0);

    // Resync at slot 5, then 0x55 completes.
    sendBits(8'h0F, 0, 4, 1'b1, 1'b1);
    checkOutput("rs_pre_slot", 32'(slot), 32'd5);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("rs_sync_err", 32'(sync_err), 32'd1);
    checkOutput("rs_slot", 32'(slot), 32'd1);
    sendBits(8'h55, 1, 7, 1'b0, 1'b1);
    checkOutput("rs_dout", 32'(dout), 32'h55);
    checkOutput("rs_sync_err_clear", 32'(sync_err), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Async reset at slot 4 with a pending frame.
    sendBits(8'hA7, 0, 7, 1'b1, 1'b0);
    sendBits(8'hC3, 0, 3, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_slot", 32'(slot), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    checkOutput("rst_valid", 32'(dout_valid), 32'd0);
    checkOutput("rst_flags", 32'({overrun, sync_err}), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("post_rst_slot", 32'(slot), 32'd0);
    checkOutput("post_rst_valid", 32'(dout_valid), 32'd0);

    // Back-to-back 0xFF then 0x00.
    validTicks.delete();
    sawOverrun = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      applyStimulus((k < N) ? 1'b1 : 1'b0, 1'b1, (k % N) == 0, 1'b1);
      if (dout_valid) validTicks.push_back(k);
      if (overrun) sawOverrun = 1'b1;
    end
    checkOutput("b2b_valid_count", 32'(validTicks.size()), 32'd2);
    if (validTicks.size() == 2) begin
      checkOutput("b2b_spacing", 32'(validTicks[1] - validTicks[0]), 32'd8);
    end
    checkOutput("b2b_no_overrun", 32'(sawOverrun), 32'd0);
    checkOutput("b2b_last_dout", 32'(dout), 32'h00);

    // Random traffic against the model.
    for (int r = 0; r < 800; r++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/tdm_demux_8.md
TDM_DEMUX_8 -- requirements
Module: tdm_demux_8

Interface
REQ-001 Parameter N, default 8, number of slots per frame; SHALL be a power of two, 2..32; slot index width SW = log2(N).
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 din  input  1  serial data bit for the current slot.
REQ-005 din_valid  input  1  din qualifier; a slot is consumed only in cycles where din_valid=1.
REQ-006 start  input  1  frame sync; when sampled with din_valid=1, din is slot 0 of a new frame.
REQ-007 slot  output  SW  index of the next slot to be captured.
REQ-008 dout  output  N  last completed frame; the bit captured at slot k is placed on dout[k].
REQ-009 dout_valid  output  1  dout holds an unconsumed frame.
REQ-010 dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-011 overrun  output  1  one-cycle pulse: a completed frame was dropped.
REQ-012 sync_err  output  1  one-cycle pulse: start arrived mid-frame.

Function
REQ-013 FSM states: IDLE (waiting for start), COLLECT (frame in progress).
REQ-014 IDLE: din_valid=1 and start=1 -> capture din to buffer bit 0, slot<=1, go to COLLECT; all other inputs are ignored.
REQ-015 COLLECT: din_valid=1 and start=0 -> capture din to buffer bit [slot], slot<=slot+1; din_valid=0 -> hold all state.
REQ-016 COLLECT: capture at slot N-1 completes the frame; slot SHALL wrap to 0 and FSM SHALL return to IDLE.
REQ-017 On completion, if dout_valid=0 or dout_ready=1 in the same cycle, dout SHALL load the full buffer and dout_valid SHALL be 1 in the next cycle (latency 1 clock after the last slot is sampled).
REQ-018 On completion with dout_valid=1 and dout_ready=0, the new frame SHALL be dropped, dout SHALL be unchanged, and overrun SHALL pulse high for one cycle.
REQ-019 dout_valid SHALL clear the cycle after a handshake unless a new frame loads in that same cycle (REQ-017), in which case it stays 1.
REQ-020 COLLECT with din_valid=1 and start=1: the partial frame SHALL be discarded, sync_err SHALL pulse, din SHALL be captured as slot 0, and slot<=1.
REQ-021 dout and dout_valid SHALL be driven only from registers; overrun and sync_err SHALL be registered pulses.
REQ-022 Buffer bits not yet written in the current frame are don't-care internally, but dout SHALL only ever present a complete frame.

Reset
REQ-023 With rst_n=0: FSM=IDLE, slot=0, buffer=0, dout=0, dout_valid=0, overrun=0, sync_err=0, regardless of clk.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame and any pending dout; the first frame after reset requires a new start.
REQ-025 Deassertion SHALL take effect at the first rising clk edge after rst_n returns high; no capture occurs in that cycle unless start and din_valid are high.

Structure
REQ-026 Shared package tdm_pkg SHALL hold the FSM state typedef (IDLE, COLLECT) and the default slot count constant (8).
REQ-027 The slot counter (enable, sync-clear to 1 or 0, wrap at N-1, terminal-count flag) SHALL be a sub-module named tdm_slot_cnt; capture, output register, and flags stay in tdm_demux_8.

Verification
REQ-028 Frame 167: start with slot 0; din sequence over slots 0..7 = 1,1,1,0,0,1,0,1; dout_ready=1 -> dout=8'hA7 (167), dout_valid=1 one cycle after slot 7, slot=0.
REQ-029 Gaps: the same frame with din_valid=0 inserted for 3 cycles after slot 3 -> slot holds at 4, result is still 8'hA7, and completion is delayed by exactly 3 cycles.
REQ-030 Backpressure: frame 8'hA7 is held with dout_ready=0, then frame 8'h3C completes -> overrun pulses once and dout stays 8'hA7; raise dout_ready -> dout_valid drops the next cycle.
REQ-031 Resync: start at slot 5 of a frame -> sync_err pulses, slot=1, and the following 7 bits of 8'h55 give dout=8'h55.
REQ-032 Reset: assert rst_n=0 asynchronously at slot 4 -> all outputs are 0 immediately; after release, din_valid without start leaves slot=0 and dout_valid=0.
REQ-033 Back-to-back frames 8'hFF then 8'h00 with continuous din_valid and dout_ready=1 -> two dout_valid cycles 8 clocks apart and no overrun.
